threshold_monitor: RTL

Parametrised, registered threshold detector with a persistence filter. Each valid sample of a WIDTH-bit unsigned input is compared against a runtime threshold in one of four modes. A level alarm (`hit`) asserts only after the condition has held for PERSIST consecutive valid samples, and a sticky flag records any trip until it is cleared. It generalises the fixed 4-bit zero / less-than-two checks in the datapath to arbitrary width, runtime threshold and mode, with persistence filtering.

---
 rtl/threshold_monitor_pkg.sv | 21 ++
 rtl/threshold_cmp.sv | 33 +++
 rtl/threshold_monitor.sv | 108 ++++++++++
 3 files changed

// File: rtl/threshold_monitor_pkg.sv
// threshold_monitor_pkg
// Shared types for the threshold monitor and its comparator.
//   mode_e  : comparison select (ZERO, LT, GE, EQ), 2-bit encoded
//   state_e : persistence filter state (IDLE, COUNTING, TRIPPED)
package threshold_monitor_pkg;

  // Encodings match the raw 2-bit mode input of the monitor.
  typedef enum logic [1:0] {
    ZERO = 2'd0,
    LT   = 2'd1,
    GE   = 2'd2,
    EQ   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    TRIPPED  = 2'd2
  } state_e;

endpackage

// File: rtl/threshold_cmp.sv
// threshold_cmp
// Purely combinational unsigned comparator, reusable wherever a sample
// must be checked against a threshold under a selectable mode.
// Ports:
//   in_i     [WIDTH-1:0] : unsigned sample
//   thresh_i [WIDTH-1:0] : unsigned threshold (unused in ZERO mode)
//   mode_i   mode_e      : comparison select
//   cond_o               : 1 when the sample satisfies the selected test
module threshold_cmp
  import threshold_monitor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic [WIDTH-1:0] thresh_i,
  input  mode_e            mode_i,
  output logic             cond_o
);

  // Select one of the four full-width unsigned tests; ZERO ignores the
  // threshold entirely.
  always_comb begin
    cond_o = 1'b0;
    unique case (mode_i)
      ZERO:    cond_o = (in_i == '0);
      LT:      cond_o = (in_i <  thresh_i);
      GE:      cond_o = (in_i >= thresh_i);
      EQ:      cond_o = (in_i == thresh_i);
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/threshold_monitor.sv
// threshold_monitor
// Registered threshold detector with a persistence filter. A level alarm
// asserts once PERSIST consecutive valid samples satisfy the comparison;
// a sticky flag remembers any trip until cleared.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid              : a sample is presented this cycle
//   in, thresh [WIDTH]    : unsigned sample and threshold
//   mode [2]              : 0=ZERO 1=LT 2=GE 3=EQ
//   clear                 : synchronous clear, overrides a same-cycle sample
//   out                   : compare result of the most recent valid sample
//   hit                   : high while tripped
//   sticky                : set on every trip, held until clear
//   run_cnt [CNT_W]       : consecutive qualifying count, saturating
module threshold_monitor
  import threshold_monitor_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PERSIST = 3,
  parameter int CNT_W   = $clog2(PERSIST + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] thresh,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             out,
  output logic             hit,
  output logic             sticky,
  output logic [CNT_W-1:0] run_cnt
);

  localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             out_q,    out_d;
  logic             sticky_q, sticky_d;
  logic             cond;
  logic [CNT_W-1:0] cnt_inc;

  threshold_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .in_i     (in),
    .thresh_i (thresh),
    .mode_i   (mode_e'(mode)),
    .cond_o   (cond)
  );

  // Next-state logic. Cycles without a valid sample hold everything, so a
  // gap never breaks a run. Clear wins over a sample in the same cycle.
  // The counter saturates at PERSIST, which keeps TRIPPED stable across
  // further qualifying samples.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    out_d     = out_q;
    sticky_d  = sticky_q;
    cnt_inc   = (run_cnt_q == PERSIST_C) ? run_cnt_q : run_cnt_q + ONE_C;

    if (clear) begin
      state_d   = IDLE;
      run_cnt_d = '0;
      out_d     = 1'b0;
      sticky_d  = 1'b0;
    end else if (in_valid) begin
      if (cond) begin
        out_d     = 1'b1;
        run_cnt_d = cnt_inc;
        if (cnt_inc == PERSIST_C) begin
          state_d  = TRIPPED;
          sticky_d = 1'b1;
        end else begin
          state_d  = COUNTING;
        end
      end else begin
        out_d     = 1'b0;
        run_cnt_d = '0;
        state_d   = IDLE;
      end
    end
  end

  // State and datapath registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      run_cnt_q <= '0;
      out_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      out_q     <= out_d;
      sticky_q  <= sticky_d;
    end
  end

  assign out     = out_q;
  assign hit     = (state_q == TRIPPED);
  assign sticky  = sticky_q;
  assign run_cnt = run_cnt_q;

endmodule
